counter: RTL and testbench



---
 rtl/counter_pkg.sv | 12 +
 rtl/counter_if.sv | 19 +
 rtl/counter_sva.sv | 54 +++++
 rtl/counter.sv | 48 ++++
 tb/tb_counter.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared defaults and types for the counter block
`timescale 1ns/1ps
package counter_pkg;

  // Default count width and reset load value used when a parent does not override them.
  localparam int unsigned DEFAULT_WIDTH       = 8;
  localparam int unsigned DEFAULT_RESET_VALUE = 0;

  // Count value at the default width.
  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage

// File: rtl/counter_if.sv
// rtl/counter_if.sv - count-enable / count-value bundle with driver, counter and observer views
`timescale 1ns/1ps
interface counter_if
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             Enable;
  logic [WIDTH-1:0] Q;

  // Whoever requests counts drives Enable and watches Q.
  modport master  (output Enable, input Q);
  // The counter itself consumes Enable and produces Q.
  modport slave   (input Enable, output Q);
  // Passive observer, used by the embedded checker.
  modport monitor (input Enable, input Q);

endinterface

// File: rtl/counter_sva.sv
// rtl/counter_sva.sv - embedded assertions and coverage for the counter
`timescale 1ns/1ps
module counter_sva
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input logic        Clock,
  input logic        Reset,
  counter_if.monitor mon
);

  localparam logic [WIDTH-1:0] RST_Q    = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = 1;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // An enabled edge must advance the count by one, wrapping at the width.
  a_inc: assert property (@(posedge Clock) disable iff (Reset)
    mon.Enable |=> (mon.Q == $past(mon.Q) + ONE))
    else $error("a_inc: Q=%0h at %0t", mon.Q, $time);

  // A disabled edge must leave the count untouched.
  a_hold: assert property (@(posedge Clock) disable iff (Reset)
    !mon.Enable |=> $stable(mon.Q))
    else $error("a_hold: Q=%0h at %0t", mon.Q, $time);

  // Enable and the count must always be driven to known levels out of reset.
  a_known: assert property (@(posedge Clock) disable iff (Reset)
    !$isunknown({mon.Enable, mon.Q}))
    else $error("a_known: Q=%0h at %0t", mon.Q, $time);

  // Checked on both clock levels rather than on Reset itself, so the check never
  // races the asynchronous load that happens in the same time step as the Reset edge.
  always @(posedge Clock or negedge Clock) begin
    if (Reset) begin
      a_rst: assert (mon.Q == RST_Q)
        else $error("a_rst: Q=%0h at %0t", mon.Q, $time);
    end
  end

  c_inc: cover property (@(posedge Clock) disable iff (Reset)
    $past(mon.Enable) && (mon.Q == $past(mon.Q) + ONE));

  c_hold: cover property (@(posedge Clock) disable iff (Reset)
    !$past(mon.Enable) && $stable(mon.Q));

  c_wrap: cover property (@(posedge Clock) disable iff (Reset)
    $past(mon.Enable) && ($past(mon.Q) == ALL_ONES) && (mon.Q == '0));

  c_rst_mid_count: cover property (@(posedge Clock)
    Reset && !$past(Reset) && $past(mon.Enable));

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - free-running up-counter with count enable and asynchronous reset
`timescale 1ns/1ps
module counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned RESET_VALUE = DEFAULT_RESET_VALUE
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] RST_Q = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = 1;

  logic [WIDTH-1:0] count_q;

  // Count register: Reset loads immediately and dominates; Enable advances modulo 2^WIDTH.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= RST_Q;
    end else if (Enable) begin
      count_q <= count_q + ONE;
    end
  end

  // Q is the register itself, so there is no combinational path from any input.
  assign Q = count_q;

`ifndef SYNTHESIS
  counter_if #(.WIDTH(WIDTH)) mon_if ();

  assign mon_if.Enable = Enable;
  assign mon_if.Q      = count_q;

  counter_sva #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_sva (
    .Clock (Clock),
    .Reset (Reset),
    .mon   (mon_if.monitor)
  );
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for the counter
`timescale 1ns/1ps
module tb_counter;
  import counter_pkg::*;

  localparam int unsigned W  = DEFAULT_WIDTH;
  localparam int unsigned RV = DEFAULT_RESET_VALUE;

  logic Clock;
  logic Reset;

  counter_if #(.WIDTH(W)) cif ();

  counter #(
    .WIDTH       (W),
    .RESET_VALUE (RV)
  ) dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Enable (cif.Enable),
    .Q      (cif.Q)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_en  = 0;
  bit armed = 1'b0;

  // Clock starts high so the first rising edge is at 10 ns, period 10 ns.
  initial begin
    Clock = 1'b1;
    forever #5 Clock = ~Clock;
  end

  // Reference: Q is the reset value plus the number of enabled edges since reset, mod 2^W.
  function automatic logic [W-1:0] model_q();
    longint unsigned v;
    v = (longint'(RV) + longint'(n_en)) % (longint'(1) << W);
    return v[W-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: Q=%0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge with the given Enable; the model counts it only if it could advance Q.
  task automatic tick(input logic en);
    cif.Enable = en;
    @(posedge Clock);
    #1;
    if (!Reset && en) n_en = n_en + 1;
  endtask

  // Per-cycle comparison against the model, mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge Clock);
      if (armed) check("cycle_q", cif.Q, model_q());
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    Reset      = 1'b0;
    cif.Enable = 1'b0;

    // Reset at 3 ns, across the 10 ns edge, released at 13 ns.
    #3;
    Reset = 1'b1;
    n_en  = 0;
    armed = 1'b1;
    #1;
    check("rst_async", cif.Q, 8'd0);
    @(posedge Clock);
    #1;
    check("rst_edge", cif.Q, 8'd0);
    #2;
    Reset = 1'b0;

    repeat (5) tick(1'b0);
    check("hold_idle", cif.Q, 8'd0);

    tick(1'b1);
    check("first_inc", cif.Q, 8'd1);
    tick(1'b0);
    check("hold_one", cif.Q, 8'd1);
    repeat (128) tick(1'b1);
    check("run_129", cif.Q, 8'd129);

    // Reset held across an edge, then preload to all ones and wrap.
    Reset = 1'b1;
    n_en  = 0;
    tick(1'b0);
    Reset = 1'b0;
    repeat (255) tick(1'b1);
    check("pre_255", cif.Q, 8'd255);
    tick(1'b1);
    check("wrap_0", cif.Q, 8'd0);

    // Count to 0x5A, then reset asynchronously between edges while enabled.
    Reset = 1'b1;
    n_en  = 0;
    tick(1'b0);
    Reset = 1'b0;
    repeat (90) tick(1'b1);
    check("pre_5a", cif.Q, 8'h5a);
    #2;
    Reset = 1'b1;
    n_en  = 0;
    #1;
    check("mid_async", cif.Q, 8'd0);
    @(posedge Clock);
    #1;
    check("mid_held", cif.Q, 8'd0);
    Reset = 1'b0;
    tick(1'b1);
    check("mid_resume", cif.Q, 8'd1);

    // Reset dominates Enable across three edges.
    repeat (3) tick(1'b1);
    check("pre_dom", cif.Q, 8'd4);
    Reset = 1'b1;
    n_en  = 0;
    repeat (3) tick(1'b1);
    check("rst_dom", cif.Q, 8'd0);
    Reset = 1'b0;
    tick(1'b1);
    check("dom_release", cif.Q, 8'd1);
    tick(1'b0);
    check("dom_hold", cif.Q, 8'd1);

    @(negedge Clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
